// File: rtl/dvi_pkg.sv
// ============================================================================
// dvi_pkg : default 640x480@60 timing, state encoding, counter width helper
// Revision 1.0
// ============================================================================
`default_nettype none

package dvi_pkg;

   localparam int unsigned DVI_H_ACTIVE = 640;
   localparam int unsigned DVI_H_FP     = 16;
   localparam int unsigned DVI_H_SYNC   = 96;
   localparam int unsigned DVI_H_BP     = 48;
   localparam int unsigned DVI_H_TOTAL  = DVI_H_ACTIVE + DVI_H_FP + DVI_H_SYNC + DVI_H_BP;

   localparam int unsigned DVI_V_ACTIVE = 480;
   localparam int unsigned DVI_V_FP     = 10;
   localparam int unsigned DVI_V_SYNC   = 2;
   localparam int unsigned DVI_V_BP     = 33;
   localparam int unsigned DVI_V_TOTAL  = DVI_V_ACTIVE + DVI_V_FP + DVI_V_SYNC + DVI_V_BP;

   localparam int unsigned DVI_COORD_W  = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } dvi_state_t;

   function automatic int unsigned axis_width(input int unsigned active, input int unsigned fp,
                                              input int unsigned sync, input int unsigned bp);
      int unsigned total;
      total = active + fp + sync + bp;
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dvi_timing_gen_if.sv
// ============================================================================
// dvi_timing_gen_if : run control, pixel request and encoder-side video timing
// Revision 1.0
// ============================================================================
`default_nettype none

interface dvi_timing_gen_if;
   import dvi_pkg::*;

   logic                   en;
   logic                   running;
   logic                   px_valid;
   logic [DVI_COORD_W-1:0] px_x;
   logic [DVI_COORD_W-1:0] px_y;
   logic                   disp_en;
   logic                   hsync;
   logic                   vsync;
   logic [1:0]             ctrl_blue;
   logic                   frame_start;
   logic                   line_start;

   modport master (
      input  en,
      output running, px_valid, px_x, px_y, disp_en, hsync, vsync,
             ctrl_blue, frame_start, line_start
   );

   modport slave (
      output en,
      input  running, px_valid, px_x, px_y, disp_en, hsync, vsync,
             ctrl_blue, frame_start, line_start
   );

endinterface

`default_nettype wire

// File: rtl/dvi_axis_counter.sv
// ============================================================================
// dvi_axis_counter : one timing axis counter with active/sync window decode
// Revision 1.0
// ============================================================================
`default_nettype none

module dvi_axis_counter
   import dvi_pkg::*;
#(
   parameter  int unsigned ACTIVE = DVI_H_ACTIVE,
   parameter  int unsigned FP     = DVI_H_FP,
   parameter  int unsigned SYNC   = DVI_H_SYNC,
   parameter  int unsigned BP     = DVI_H_BP,
   localparam int unsigned W      = axis_width(ACTIVE, FP, SYNC, BP)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         active,
   output logic         sync_active
);

   localparam int unsigned TOTAL    = ACTIVE + FP + SYNC + BP;
   localparam int unsigned SYNC_BEG = ACTIVE + FP;
   localparam int unsigned SYNC_END = ACTIVE + FP + SYNC;

   logic [31:0] count_ext;

   // Decode in 32 bits so a sync window ending exactly at 2**W cannot alias.
   assign count_ext   = 32'(count);
   assign wrap        = (count_ext == TOTAL - 1);
   assign active      = (count_ext < ACTIVE);
   assign sync_active = (count_ext >= SYNC_BEG) && (count_ext < SYNC_END);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/dvi_timing_gen.sv
// ============================================================================
// dvi_timing_gen : DVI raster timing with a 1-cycle pixel request lead
// Revision 1.0
// ============================================================================
`default_nettype none

module dvi_timing_gen
   import dvi_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DVI_H_ACTIVE,
   parameter int unsigned H_FP     = DVI_H_FP,
   parameter int unsigned H_SYNC   = DVI_H_SYNC,
   parameter int unsigned H_BP     = DVI_H_BP,
   parameter int unsigned V_ACTIVE = DVI_V_ACTIVE,
   parameter int unsigned V_FP     = DVI_V_FP,
   parameter int unsigned V_SYNC   = DVI_V_SYNC,
   parameter int unsigned V_BP     = DVI_V_BP,
   parameter bit          HS_POL   = 1'b0,
   parameter bit          VS_POL   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   dvi_timing_gen_if.master vid
);

   localparam int unsigned HW = axis_width(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int unsigned VW = axis_width(V_ACTIVE, V_FP, V_SYNC, V_BP);

   dvi_state_t state;
   dvi_state_t state_nxt;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_wrap, h_act, h_sync;
   logic          v_wrap, v_act, v_sync;
   logic          cnt_run;
   logic          cnt_clr;

   logic                   s1_valid;
   logic [DVI_COORD_W-1:0] s1_x;
   logic [DVI_COORD_W-1:0] s1_y;
   logic                   s1_hs, s1_vs, s1_fs, s1_ls;

   logic s2_de, s2_hsync, s2_vsync, s2_fs, s2_ls;

   assign cnt_run = (state != IDLE);
   assign cnt_clr = (state == IDLE);

   dvi_axis_counter #(
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP),
      .SYNC   (H_SYNC),
      .BP     (H_BP)
   ) u_h_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (cnt_clr),
      .inc         (cnt_run),
      .count       (h_cnt),
      .wrap        (h_wrap),
      .active      (h_act),
      .sync_active (h_sync)
   );

   dvi_axis_counter #(
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP),
      .SYNC   (V_SYNC),
      .BP     (V_BP)
   ) u_v_cnt (
      .clk         (clk),
      .rst         (rst),
      .clr         (cnt_clr),
      .inc         (cnt_run && h_wrap),
      .count       (v_cnt),
      .wrap        (v_wrap),
      .active      (v_act),
      .sync_active (v_sync)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A re-request during DRAIN resumes RUN without touching the counters.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (vid.en) state_nxt = RUN;
         end
         RUN: begin
            if (!vid.en) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (vid.en)                 state_nxt = RUN;
            else if (h_wrap && v_wrap)  state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_x     <= '0;
         s1_y     <= '0;
         s1_hs    <= 1'b0;
         s1_vs    <= 1'b0;
         s1_fs    <= 1'b0;
         s1_ls    <= 1'b0;
         s2_de    <= 1'b0;
         s2_hsync <= ~HS_POL;
         s2_vsync <= ~VS_POL;
         s2_fs    <= 1'b0;
         s2_ls    <= 1'b0;
      end else begin
         s1_valid <= cnt_run && h_act && v_act;
         s1_x     <= DVI_COORD_W'(h_cnt);
         s1_y     <= DVI_COORD_W'(v_cnt);
         s1_hs    <= cnt_run && h_sync;
         s1_vs    <= cnt_run && v_sync;
         s1_fs    <= cnt_run && (h_cnt == '0) && (v_cnt == '0);
         s1_ls    <= cnt_run && (h_cnt == '0);
         s2_de    <= s1_valid;
         s2_hsync <= s1_hs ? HS_POL : ~HS_POL;
         s2_vsync <= s1_vs ? VS_POL : ~VS_POL;
         s2_fs    <= s1_fs;
         s2_ls    <= s1_ls;
      end
   end

   assign vid.running     = cnt_run;
   assign vid.px_valid    = s1_valid;
   assign vid.px_x        = s1_x;
   assign vid.px_y        = s1_y;
   assign vid.disp_en     = s2_de;
   assign vid.hsync       = s2_hsync;
   assign vid.vsync       = s2_vsync;
   assign vid.ctrl_blue   = {s2_vsync, s2_hsync};
   assign vid.frame_start = s2_fs;
   assign vid.line_start  = s2_ls;

endmodule

`default_nettype wire

// File: doc/dvi_timing_gen.md
DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 96, hsync width in pixels.
REQ-004 SHALL have parameter H_BP, default 48, horizontal back porch in pixels (H_TOTAL = 800).
REQ-005 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-006 SHALL have parameter V_FP, default 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 2, vsync width in lines.
REQ-008 SHALL have parameter V_BP, default 33, vertical back porch in lines (V_TOTAL = 525).
REQ-009 SHALL have parameters HS_POL and VS_POL, default 0, active level of hsync/vsync (0 = active-low).
REQ-010 SHALL have ports: clk input 1, pixel clock; rst input 1, reset.
REQ-011 SHALL have ports: en input 1, run request; running output 1, frame generation in progress.
REQ-012 SHALL have ports: px_valid output 1, pixel request; px_x output 10, column; px_y output 10, row.
REQ-013 SHALL have ports: disp_en output 1, active video to encoders; hsync output 1; vsync output 1.
REQ-014 SHALL have ports: ctrl_blue output 2, {vsync,hsync} to the blue-channel encoder ctrl input; frame_start output 1; line_start output 1.
REQ-015 SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-016 SHALL keep counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1); h_cnt SHALL increment every cycle in RUN.
REQ-017 h_cnt SHALL wrap to 0 after H_TOTAL-1; v_cnt SHALL increment on that wrap and wrap to 0 after V_TOTAL-1.
REQ-018 Counter widths SHALL be $clog2(H_TOTAL) and $clog2(V_TOTAL); comparisons SHALL be unsigned with no overflow.
REQ-019 State machine SHALL have states IDLE, RUN, DRAIN.
REQ-020 IDLE -> RUN SHALL occur on the first cycle en=1; counters SHALL be 0 on entry.
REQ-021 RUN -> DRAIN SHALL occur when en=0; DRAIN SHALL complete the current frame.
REQ-022 DRAIN -> IDLE SHALL occur at (h_cnt,v_cnt)=(H_TOTAL-1,V_TOTAL-1); DRAIN -> RUN SHALL occur if en=1 again before that point, with no counter disturbance.
REQ-023 In IDLE the counters SHALL hold 0 and running SHALL be 0; running SHALL be 1 in RUN and DRAIN.
REQ-024 Stage 1 (registered from counters): px_valid = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE && state!=IDLE); px_x = h_cnt; px_y = v_cnt.
REQ-025 Stage 2 (registered from stage 1): disp_en SHALL assert exactly one cycle after px_valid for the same pixel, giving a pixel source one cycle of latency.
REQ-026 hsync SHALL be active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751; it SHALL be aligned to disp_en timing (stage 2).
REQ-027 vsync SHALL be active for whole lines with v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 490..491, aligned at stage 2.
REQ-028 Output levels SHALL be: active = POL, inactive = ~POL; ctrl_blue SHALL equal {vsync,hsync} as driven.
REQ-029 frame_start SHALL pulse for 1 cycle at stage 2 for (0,0); line_start SHALL pulse for 1 cycle at stage 2 for h_cnt=0 on every line.
REQ-030 In IDLE, sync SHALL be inactive and disp_en, px_valid, frame_start and line_start SHALL be 0; pipeline contents SHALL drain naturally over 2 cycles.

Reset
REQ-031 rst SHALL force state=IDLE, h_cnt=0, v_cnt=0, px_valid=0, px_x=0, px_y=0, disp_en=0, frame_start=0, line_start=0, running=0, hsync=~HS_POL, vsync=~VS_POL, ctrl_blue={~VS_POL,~HS_POL}.
REQ-032 rst mid-frame SHALL take effect at the next edge and override en; the first frame after release SHALL restart at (0,0).

Structure
REQ-033 dvi_pkg SHALL hold the default timing constants, derived H_TOTAL/V_TOTAL, and the state enum typedef.
REQ-034 One sub-module, dvi_axis_counter, SHALL be instantiated twice (horizontal, vertical), parameterized by active/fp/sync/bp, with outputs count, wrap, active, sync_active.

Verification
REQ-035 rst released, en=1 held: first px_valid at cycle 1 after RUN entry, disp_en 1 cycle later; exactly 640 disp_en cycles per line and 307200 per frame.
REQ-036 Line timing: hsync low (HS_POL=0) for 96 cycles starting 656 cycles after line_start; line_start period = 800 cycles.
REQ-037 Frame timing: vsync low for 1600 cycles (2 lines) starting at line 490; frame_start period = 420000 cycles.
REQ-038 en dropped at line 100: running stays 1, frame finishes, IDLE entered after (799,524); no disp_en afterward; ctrl_blue=2'b11.
REQ-039 en dropped then reasserted within the same frame: no counter discontinuity; frame_start period stays 420000.
REQ-040 rst pulsed at (300,200): next cycle all outputs equal their reset values; after release with en=1, frame_start occurs 2 cycles after RUN entry.
